// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: writeback write port, decode reserve port and
// the combinational read ports with their busy flags and the sticky hazard flag.
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       hazard_err;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
    input  rd_data, rd_busy, hazard_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
    output rd_data, rd_busy, hazard_err
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending scoreboard and XZR.
// Optional same-cycle write-to-read forwarding under `define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 2**ADDR_W-1
) (
  input logic          clk,
  input logic          reset_n,
  regfile_mp_if.slave  bus
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_pend;
  logic                     r_hazard_err;
  logic                     w_wr_ok;
  logic                     w_rsv_ok;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  assign w_wr_ok  = bus.wr_en  && (bus.wr_addr  != ZERO_ADDR);
  assign w_rsv_ok = bus.rsv_en && (bus.rsv_addr != ZERO_ADDR);

  // Register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard: a same-cycle reserve overrides the clear from the write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
    end else begin
      if (w_wr_ok) begin
        r_pend[bus.wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_pend[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  // Sticky flag for reserving a register that is still pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hazard_err <= 1'b0;
    end else if (w_rsv_ok && r_pend[bus.rsv_addr]) begin
      r_hazard_err <= 1'b1;
    end
  end

  // Combinational read ports
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] w_addr;
      w_addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (w_addr == ZERO_ADDR) begin
        w_rd_data[p*DATA_W +: DATA_W] = '0;
        w_rd_busy[p]                  = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_ok && (w_addr == bus.wr_addr)) begin
        w_rd_data[p*DATA_W +: DATA_W] = bus.wr_data;
        w_rd_busy[p]                  = w_rsv_ok && (bus.rsv_addr == w_addr);
`endif
      end else begin
        w_rd_data[p*DATA_W +: DATA_W] = r_mem[w_addr];
        w_rd_busy[p]                  = r_pend[w_addr];
      end
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.hazard_err = r_hazard_err;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios, then randomized
// traffic compared against an array-based model of the register file rules.
module tb_regfile_mp;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;
  localparam int ZR     = 31;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] m_mem [32];
  logic        m_pend [32];
  logic        m_err;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 64'd0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [63:0] exp_data(input int a);
    if (a == ZR) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (int'(bus.wr_addr) == a)) return bus.wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == ZR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (int'(bus.wr_addr) == a)) return bus.rsv_en && (int'(bus.rsv_addr) == a);
`endif
    return m_pend[a];
  endfunction

  function automatic logic [63:0] port_data(input int p);
    return bus.rd_data[p*DATA_W +: DATA_W];
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NUM_RD; p++) begin
      int a;
      a = int'(bus.rd_addr[p*ADDR_W +: ADDR_W]);
      chk($sformatf("%s_d%0d", tag, p), port_data(p), exp_data(a));
      chk($sformatf("%s_b%0d", tag, p), {63'd0, bus.rd_busy[p]}, {63'd0, exp_busy(a)});
    end
    chk($sformatf("%s_err", tag), {63'd0, bus.hazard_err}, {63'd0, m_err});
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic re, input logic [4:0] ra, input logic [19:0] rds);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra;
    bus.rd_addr  = rds;
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    logic we, re;
    int wa, ra;
    logic [63:0] wd;
    we = bus.wr_en; wa = int'(bus.wr_addr); wd = bus.wr_data;
    re = bus.rsv_en; ra = int'(bus.rsv_addr);
    @(posedge clk);
    if (reset_n) begin
      if (re && ra != ZR && m_pend[ra]) m_err = 1'b1;
      if (we && wa != ZR) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (re && ra != ZR) m_pend[ra] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_all("rst_rel");
  endtask

  initial begin
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 20'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // reset in the middle of operation after writing X5
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, {15'd0, 5'd5});
    #1 check_all("w5_same");
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {15'd0, 5'd5});
    #1 chk("w5_post", port_data(0), 64'hDEAD_BEEF);
    #2 reset_n = 1'b0;
    #1 model_reset();
    chk("w5_rst", port_data(0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("w5_rel_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
    chk("w5_rel_err", {63'd0, bus.hazard_err}, 64'd0);

    // four-port read
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 64'(i * 17), 1'b0, 5'd0, 20'd0);
      tick();
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {5'd31, 5'd1, 5'd1, 5'd4});
    #1 chk("fp0", port_data(0), 64'h44);
    chk("fp1", port_data(1), 64'h11);
    chk("fp2", port_data(2), 64'h11);
    chk("fp3", port_data(3), 64'h0);
    chk("fp_busy", {60'd0, bus.rd_busy}, 64'd0);
    @(negedge clk);

    // scoreboard on X7
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, {15'd0, 5'd7});
    tick();
    #1 chk("sb_rsv_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
    drive(1'b1, 5'd7, 64'h99, 1'b0, 5'd0, {15'd0, 5'd7});
    tick();
    #1 chk("sb_wr_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
    chk("sb_wr_data", port_data(0), 64'h99);
    drive(1'b1, 5'd7, 64'h99, 1'b1, 5'd7, {15'd0, 5'd7});
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {15'd0, 5'd7});
    #1 chk("sb_both_data", port_data(0), 64'h99);
    chk("sb_both_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
    chk("sb_both_err", {63'd0, bus.hazard_err}, 64'd0);
    @(negedge clk);

    // double reserve of X3
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, {15'd0, 5'd3});
    tick();
    #1 chk("hz_first", {63'd0, bus.hazard_err}, 64'd0);
    tick();
    #1 chk("hz_second", {63'd0, bus.hazard_err}, 64'd1);
    drive(1'b1, 5'd3, 64'h5, 1'b0, 5'd0, {15'd0, 5'd3});
    tick();
    #1 chk("hz_sticky", {63'd0, bus.hazard_err}, 64'd1);
    check_all("hz_model");

    // zero register ignores write and reserve
    drive(1'b1, 5'd31, 64'hFFFF, 1'b1, 5'd31, {5'd31, 5'd31, 5'd31, 5'd31});
    #1 check_all("zr_same");
    tick();
    #1 chk("zr_data", port_data(0), 64'd0);
    chk("zr_busy", {60'd0, bus.rd_busy}, 64'd0);
    chk("zr_err", {63'd0, bus.hazard_err}, 64'd1);

    // same-cycle write and read of a reserved X9
    do_reset();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, {15'd0, 5'd9});
    tick();
    drive(1'b1, 5'd9, 64'h1234, 1'b0, 5'd0, {15'd0, 5'd9});
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp_data", port_data(0), 64'h1234);
    chk("byp_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
`else
    #1 chk("byp_data", port_data(0), 64'd0);
    chk("byp_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
`endif
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, {15'd0, 5'd9});
    #1 chk("byp_next_data", port_data(0), 64'h1234);
    chk("byp_next_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
    @(negedge clk);

    // randomized traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [19:0] rds;
      logic [4:0]  wa, ra;
      for (int p = 0; p < NUM_RD; p++) begin
        rds[p*5 +: 5] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      end
      wa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            1'($urandom_range(0, 3) == 0), ra, rds);
      #1 check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
